// File: rtl/dds_multi.sv
// dds_multi: multi-channel DDS with shadowed configuration,
// quarter-wave sine LUT and amplitude scaling about midscale.
module dds_multi #(
  parameter int CHANNELS = 2,
  parameter int PHASE_WIDTH = 32,
  parameter int OUTPUT_WIDTH = 12,
  parameter int LUT_ADDR_WIDTH = 10,
  localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           cfg_wr,
  input  logic [CW-1:0]                  cfg_ch,
  input  logic [2:0]                     cfg_addr,
  input  logic [PHASE_WIDTH-1:0]         cfg_data,
  input  logic                           update,
  input  logic                           sync,
  output logic [CHANNELS*OUTPUT_WIDTH-1:0] wave_out,
  output logic [CHANNELS-1:0]            wave_valid
);

  localparam int W = OUTPUT_WIDTH;
  localparam int PW = PHASE_WIDTH;
  localparam int LA = LUT_ADDR_WIDTH;
  localparam int LN = 1 << LA;
  localparam int XW = 2 * W + 5;
  localparam logic [W-1:0] MID = {1'b1, {(W-1){1'b0}}};
  localparam logic signed [XW-1:0] MID_X = {{(XW-W){1'b0}}, MID};
  localparam logic signed [XW-1:0] MAX_X = {{(XW-W){1'b0}}, {W{1'b1}}};

  typedef struct packed {
    logic [PW-1:0] freq;
    logic [PW-1:0] phase;
    logic [2:0]    mode;
    logic [W:0]    duty;
    logic [W:0]    amp;
    logic          en;
  } cfg_t;

  localparam cfg_t CFG_RST = '{
    freq: '0,
    phase: '0,
    mode: 3'd0,
    duty: {2'b01, {(W-1){1'b0}}},
    amp: {1'b1, {W{1'b0}}},
    en: 1'b0
  };

  // Q30 Taylor series so the table is built from integer math only
  function automatic logic [W-2:0] sin_val(input int a);
    longint x, x2, t, s, r;
    x = (longint'(a) * 64'sd3373259426) >>> (LA + 1);
    x2 = (x * x) >>> 30;
    t = x;
    s = x;
    for (int k = 1; k <= 6; k++) begin
      t = -((t * x2) >>> 30) / longint'(2 * k * (2 * k + 1));
      s = s + t;
    end
    r = (s * longint'((1 << (W - 1)) - 1) + (64'sd1 <<< 29)) >>> 30;
    return r[W-2:0];
  endfunction

  logic [W-2:0] lut [LN];

  for (genvar i = 0; i < LN; i++) begin : g_lut
    localparam logic [W-2:0] V = sin_val(i);
    assign lut[i] = V;
  end

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    cfg_t sh_q, sh_d, act_q, act_d;
    logic [PW-1:0] acc_q, acc_d, ps1_q, ps1_d;
    logic [2:0] mode1_q, mode1_d;
    logic [W:0] duty1_q, duty1_d, amp1_q, amp1_d;
    logic [W:0] amp2_q, amp2_d;
    logic en1_q, en1_d, en2_q, en2_d, vld_q, vld_d;
    logic [W-1:0] raw2_q, raw2_d, out_q, out_d, p, sat;
    logic [1:0] quad;
    logic [LA-1:0] la;
    logic [W-2:0] lv;
    logic signed [XW-1:0] diff, prod, scl;
    logic unused_ps;

    assign unused_ps = ^ps1_q;

    always_comb begin
      sh_d = sh_q;
      if (cfg_wr && (32'(cfg_ch) == c)) begin
        case (cfg_addr)
          3'd0: sh_d.freq = cfg_data;
          3'd1: sh_d.phase = cfg_data;
          3'd2: sh_d.mode = cfg_data[2:0];
          3'd3: sh_d.duty = cfg_data[W:0];
          3'd4: sh_d.amp = cfg_data[W:0];
          3'd5: sh_d.en = cfg_data[0];
          default: ;
        endcase
      end
      act_d = update ? sh_d : act_q;
      acc_d = acc_q;
      if (sync) acc_d = '0;
      else if (act_q.en) acc_d = acc_q + act_q.freq;
    end

    always_comb begin
      ps1_d = acc_q + act_q.phase;
      mode1_d = act_q.mode;
      duty1_d = act_q.duty;
      amp1_d = act_q.amp;
      en1_d = act_q.en;
      p = ps1_q[PW-1 -: W];
      quad = ps1_q[PW-1 -: 2];
      la = ps1_q[PW-3 -: LA];
      lv = lut[quad[0] ? ~la : la];
      case (mode1_q)
        3'd0: raw2_d = quad[1] ? MID - {1'b0, lv} : MID + {1'b0, lv};
        3'd1: raw2_d = p[W-1] ? ~{p[W-2:0], 1'b0} : {p[W-2:0], 1'b0};
        3'd2: raw2_d = p;
        3'd3: raw2_d = ({1'b0, p} < duty1_q) ? {W{1'b1}} : {W{1'b0}};
        default: raw2_d = MID;
      endcase
      amp2_d = amp1_q;
      en2_d = en1_q;
    end

    always_comb begin
      diff = {{(XW-W){1'b0}}, raw2_q} - MID_X;
      prod = diff * $signed({{(XW-W-1){1'b0}}, amp2_q});
      scl = (prod >>> W) + MID_X;
      if (scl < 0) sat = '0;
      else if (scl > MAX_X) sat = '1;
      else sat = scl[W-1:0];
      out_d = en2_q ? sat : MID;
      vld_d = en2_q;
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        sh_q <= CFG_RST;
        act_q <= CFG_RST;
        acc_q <= '0;
        ps1_q <= '0;
        mode1_q <= '0;
        duty1_q <= '0;
        amp1_q <= '0;
        en1_q <= 1'b0;
        raw2_q <= MID;
        amp2_q <= '0;
        en2_q <= 1'b0;
        out_q <= MID;
        vld_q <= 1'b0;
      end else begin
        sh_q <= sh_d;
        act_q <= act_d;
        acc_q <= acc_d;
        ps1_q <= ps1_d;
        mode1_q <= mode1_d;
        duty1_q <= duty1_d;
        amp1_q <= amp1_d;
        en1_q <= en1_d;
        raw2_q <= raw2_d;
        amp2_q <= amp2_d;
        en2_q <= en2_d;
        out_q <= out_d;
        vld_q <= vld_d;
      end
    end

    assign wave_out[c*W +: W] = out_q;
    assign wave_valid[c] = vld_q;
  end

endmodule

// File: tb/tb_dds_multi.sv
// tb_dds_multi: scoreboard model plus table vectors and
// hand sequences for the multi-cycle cases of dds_multi.
module tb_dds_multi;

  localparam int CH = 2;
  localparam int W = 12;
  localparam int M = 2048;
  localparam real PI = 3.14159265358979323846;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic cfg_wr = 1'b0;
  logic update = 1'b0;
  logic sync = 1'b0;
  logic [0:0] cfg_ch = '0;
  logic [2:0] cfg_addr = '0;
  logic [31:0] cfg_data = '0;
  logic [CH*W-1:0] wave_out;
  logic [CH-1:0] wave_valid;

  dds_multi #(
    .CHANNELS(CH),
    .PHASE_WIDTH(32),
    .OUTPUT_WIDTH(W),
    .LUT_ADDR_WIDTH(10)
  ) dut (
    .clock(clock),
    .reset(reset),
    .cfg_wr(cfg_wr),
    .cfg_ch(cfg_ch),
    .cfg_addr(cfg_addr),
    .cfg_data(cfg_data),
    .update(update),
    .sync(sync),
    .wave_out(wave_out),
    .wave_valid(wave_valid)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] freq;
    logic [31:0] phase;
    int mode;
    int duty;
    int amp;
    bit en;
  } mcfg_t;

  typedef struct packed {
    logic [CH*W-1:0] v;
    logic [CH-1:0] vl;
    logic [CH-1:0] tol;
  } exp_t;

  typedef struct {
    int mode;
    logic [31:0] phase;
    int duty;
    int amp;
    int want;
  } vec_t;

  mcfg_t sh [CH];
  mcfg_t act [CH];
  logic [31:0] acc [CH];
  exp_t sbq [$];
  vec_t vt [15];
  int ncmp = 0;
  int nerr = 0;
  int cyc = 0;

  function automatic mcfg_t cfg_rst();
    mcfg_t r;
    r.freq = '0;
    r.phase = '0;
    r.mode = 0;
    r.duty = M;
    r.amp = 4096;
    r.en = 1'b0;
    return r;
  endfunction

  function automatic int model_raw(int c);
    logic [31:0] ps;
    logic [11:0] p;
    int r, ai;
    ps = acc[c] + act[c].phase;
    p = ps[31:20];
    case (act[c].mode)
      0: begin
        ai = ps[30] ? 1023 - int'(ps[29:20]) : int'(ps[29:20]);
        r = $rtoi(2047.0 * $sin(real'(ai) * PI / 2048.0) + 0.5);
        return ps[31] ? M - r : M + r;
      end
      1: return p[11] ? 4095 - 2 * int'(p[10:0]) : 2 * int'(p[10:0]);
      2: return int'(p);
      3: return (int'(p) < act[c].duty) ? 4095 : 0;
      default: return M;
    endcase
  endfunction

  function automatic int model_out(int c);
    int d, s;
    if (!act[c].en) return M;
    d = (model_raw(c) - M) * act[c].amp;
    s = M + (d >>> W);
    if (s < 0) return 0;
    if (s > 4095) return 4095;
    return s;
  endfunction

  function automatic exp_t model_exp();
    exp_t e;
    e = '0;
    for (int c = 0; c < CH; c++) begin
      e.v[c*W +: W] = W'(model_out(c));
      e.vl[c] = act[c].en;
      e.tol[c] = act[c].en && (act[c].mode == 0);
    end
    return e;
  endfunction

  function automatic exp_t idle_exp();
    exp_t e;
    e = '0;
    for (int c = 0; c < CH; c++) e.v[c*W +: W] = W'(M);
    return e;
  endfunction

  function automatic int ch_out(int c);
    return int'(wave_out[c*W +: W]);
  endfunction

  task automatic model_edge(bit r, bit w, int ch, int ad,
                            logic [31:0] d, bit u, bit s);
    for (int c = 0; c < CH; c++) begin
      if (r) begin
        sh[c] = cfg_rst();
        act[c] = cfg_rst();
        acc[c] = '0;
      end else begin
        if (w && ch == c) begin
          case (ad)
            0: sh[c].freq = d;
            1: sh[c].phase = d;
            2: sh[c].mode = int'(d[2:0]);
            3: sh[c].duty = int'(d[12:0]);
            4: sh[c].amp = int'(d[12:0]);
            5: sh[c].en = d[0];
            default: ;
          endcase
        end
        if (s) acc[c] = '0;
        else if (act[c].en) acc[c] = acc[c] + act[c].freq;
        if (u) act[c] = sh[c];
      end
    end
  endtask

  task automatic chk(string nm, int got, int want);
    ncmp++;
    if (got != want) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, got, want);
    end
  endtask

  task automatic step();
    bit r, w, u, s, ok;
    int ch, ad, got, want;
    logic [31:0] d;
    exp_t e;
    r = reset;
    w = cfg_wr;
    u = update;
    s = sync;
    ch = int'(cfg_ch);
    ad = int'(cfg_addr);
    d = cfg_data;
    @(posedge clock);
    #1;
    cyc++;
    model_edge(r, w, ch, ad, d, u, s);
    if (r) begin
      sbq.delete();
      for (int c = 0; c < CH; c++) begin
        chk($sformatf("reset_out%0d", c), ch_out(c), M);
        chk($sformatf("reset_vld%0d", c), int'(wave_valid[c]), 0);
      end
      sbq.push_back(idle_exp());
      sbq.push_back(idle_exp());
    end else if (sbq.size() == 0) begin
      ncmp++;
      nerr++;
      $display("FAIL sb_empty cyc %0d: got no entry expected one", cyc);
    end else begin
      e = sbq.pop_front();
      for (int c = 0; c < CH; c++) begin
        got = ch_out(c);
        want = int'(e.v[c*W +: W]);
        ok = (wave_valid[c] === e.vl[c]);
        if (e.tol[c]) ok = ok && (got - want <= 1) && (want - got <= 1);
        else ok = ok && (got == want);
        ncmp++;
        if (!ok) begin
          nerr++;
          $display("FAIL sb_ch%0d cyc %0d: got %0d valid %0b expected %0d valid %0b",
                   c, cyc, got, wave_valid[c], want, e.vl[c]);
        end
      end
    end
    sbq.push_back(model_exp());
  endtask

  task automatic wr(int ch, int ad, logic [31:0] d);
    cfg_wr = 1'b1;
    cfg_ch = 1'(ch);
    cfg_addr = 3'(ad);
    cfg_data = d;
    step();
    cfg_wr = 1'b0;
  endtask

  task automatic upd(bit s);
    update = 1'b1;
    sync = s;
    step();
    update = 1'b0;
    sync = 1'b0;
  endtask

  task automatic run(int n);
    repeat (n) step();
  endtask

  initial begin
    int mx, mn, prv, last, ncross, per, hi, lo, v0;

    vt[0]  = '{2, 32'h0000_0000, M, 4096, 0};
    vt[1]  = '{2, 32'h8000_0000, M, 4096, 2048};
    vt[2]  = '{2, 32'hFFF0_0000, M, 2048, 3071};
    vt[3]  = '{2, 32'h0000_0000, M, 2048, 1024};
    vt[4]  = '{1, 32'h4000_0000, M, 4096, 2048};
    vt[5]  = '{1, 32'hC000_0000, M, 4096, 2047};
    vt[6]  = '{3, 32'h0000_0000, 1024, 4096, 4095};
    vt[7]  = '{3, 32'h0000_0000, 0, 4096, 0};
    vt[8]  = '{3, 32'hFFF0_0000, 4096, 4096, 4095};
    vt[9]  = '{5, 32'h1234_5678, M, 4096, 2048};
    vt[10] = '{2, 32'h1230_0000, M, 0, 2048};
    vt[11] = '{0, 32'h4000_0000, M, 4096, 4095};
    vt[12] = '{0, 32'h0000_0000, M, 4096, 2048};
    vt[13] = '{2, 32'hFFF0_0000, M, 8191, 4095};
    vt[14] = '{2, 32'h0000_0000, M, 8191, 0};

    run(2);
    reset = 1'b0;

    // single sine channel from reset
    wr(0, 0, 32'h028F_5C29);
    wr(0, 2, 0);
    wr(0, 5, 1);
    upd(1'b0);
    run(2);
    chk("vld_early", int'(wave_valid[0]), 0);
    run(1);
    chk("vld_rise", int'(wave_valid[0]), 1);
    mx = 0;
    mn = 4095;
    prv = M;
    last = -1;
    ncross = 0;
    for (int i = 0; i < 500; i++) begin
      step();
      v0 = ch_out(0);
      if (v0 > mx) mx = v0;
      if (v0 < mn) mn = v0;
      if (prv < M && v0 >= M) begin
        if (last >= 0) begin
          per = i - last;
          ncmp++;
          if (per < 99 || per > 101) begin
            nerr++;
            $display("FAIL period: got %0d expected 99..101", per);
          end
        end
        last = i;
        ncross++;
      end
      prv = v0;
    end
    chk("sine_max", mx, 4095);
    chk("sine_min", mn, 1);
    chk("crossings", int'(ncross >= 4), 1);
    chk("ch1_mid", ch_out(1), M);
    chk("ch1_vld", int'(wave_valid[1]), 0);

    // table of static samples taken right after a sync
    for (int v = 0; v < 15; v++) begin
      wr(0, 1, vt[v].phase);
      wr(0, 2, 32'(vt[v].mode));
      wr(0, 3, 32'(vt[v].duty));
      wr(0, 4, 32'(vt[v].amp));
      wr(0, 0, 32'h0);
      upd(1'b1);
      run(3);
      chk($sformatf("vec%0d", v), ch_out(0), vt[v].want);
    end

    // two sawtooths a quarter period apart
    wr(0, 0, 32'h0100_0000);
    wr(0, 1, 32'h0);
    wr(0, 2, 2);
    wr(0, 4, 4096);
    wr(1, 0, 32'h0100_0000);
    wr(1, 1, 32'h4000_0000);
    wr(1, 2, 2);
    wr(1, 5, 1);
    upd(1'b1);
    run(3);
    chk("b_first0", ch_out(0), 0);
    chk("b_first1", ch_out(1), 1024);
    for (int i = 0; i < 300; i++) begin
      step();
      if (wave_valid == 2'b11)
        chk("b_diff", (ch_out(1) - ch_out(0)) & 4095, 1024);
    end

    // square duty cycle over one full period
    wr(0, 2, 3);
    wr(0, 3, 1024);
    upd(1'b1);
    run(2);
    hi = 0;
    lo = 0;
    for (int i = 0; i < 256; i++) begin
      step();
      if (ch_out(0) == 4095) hi++;
      else if (ch_out(0) == 0) lo++;
    end
    chk("sq_high", hi, 64);
    chk("sq_low", lo, 192);

    // shadow writes stay invisible until update
    wr(0, 0, 32'h0);
    wr(0, 2, 2);
    wr(1, 0, 32'h0);
    wr(1, 1, 32'h0);
    upd(1'b1);
    run(3);
    wr(0, 0, 32'h0010_0000);
    wr(1, 0, 32'h0020_0000);
    wr(0, 6, 32'hFFFF_FFFF);
    wr(1, 7, 32'h1234_5678);
    for (int i = 0; i < 200; i++) begin
      step();
      if (i % 50 == 0) begin
        chk("hold0", ch_out(0), 0);
        chk("hold1", ch_out(1), 0);
      end
    end
    upd(1'b0);
    run(3);
    chk("d_n3_ch0", ch_out(0), 0);
    chk("d_n3_ch1", ch_out(1), 0);
    run(1);
    chk("d_n4_ch0", ch_out(0), 1);
    chk("d_n4_ch1", ch_out(1), 2);

    // reset wins over concurrent write/update/sync
    run(10);
    reset = 1'b1;
    cfg_wr = 1'b1;
    cfg_ch = 1'b0;
    cfg_addr = 3'd5;
    cfg_data = 32'h1;
    update = 1'b1;
    sync = 1'b1;
    step();
    reset = 1'b0;
    cfg_wr = 1'b0;
    update = 1'b0;
    sync = 1'b0;
    run(20);
    chk("e_out0", ch_out(0), M);
    chk("e_out1", ch_out(1), M);
    chk("e_vld0", int'(wave_valid[0]), 0);

    // write and update in the same cycle
    cfg_wr = 1'b1;
    cfg_ch = 1'b0;
    cfg_addr = 3'd5;
    cfg_data = 32'h1;
    update = 1'b1;
    step();
    cfg_wr = 1'b0;
    update = 1'b0;
    run(2);
    chk("wu_early", int'(wave_valid[0]), 0);
    run(1);
    chk("wu_vld", int'(wave_valid[0]), 1);
    chk("wu_out", ch_out(0), M);
    run(5);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/dds_multi.md
# dds_multi

Multi-channel, parametrised successor to the single-channel DDS generator. Each of `CHANNELS` independent phase accumulators drives a selectable waveform: sine, triangle, sawtooth, or square with programmable duty. Each channel has programmable amplitude scaling about midscale. Configuration is double-buffered so all channels change coherently. A global sync restarts every accumulator at once. The block sits between the command/config decoder and the DAC output mux.

## Interface
- `CHANNELS`, 2: number of generator channels (1..8)
- `PHASE_WIDTH`, 32: accumulator, frequency and phase word width
- `OUTPUT_WIDTH`, 12: sample width W, unsigned offset-binary, midscale M = 2^(W-1)
- `LUT_ADDR_WIDTH`, 10: quarter-wave sine LUT address width; requires LUT_ADDR_WIDTH+2 <= PHASE_WIDTH
- `clock`  in  1  system clock
- `reset`  in  1  reset, synchronous, active-high
- `cfg_wr`  in  1  write strobe into the shadow register selected by `cfg_ch`/`cfg_addr`
- `cfg_ch`  in  $clog2(CHANNELS) (min 1)  channel select; values >= CHANNELS are ignored
- `cfg_addr`  in  3  0=FREQ, 1=PHASE, 2=MODE[2:0], 3=DUTY[W:0], 4=AMP[W:0], 5=EN[0]; 6,7 are ignored
- `cfg_data`  in  PHASE_WIDTH  write data, LSB-aligned, upper bits ignored
- `update`  in  1  copies all shadow registers of all channels to the active registers at one edge
- `sync`  in  1  clears all accumulators at one edge
- `wave_out`  out  CHANNELS*W  channel c sample at bits [c*W +: W]
- `wave_valid`  out  CHANNELS  per-channel valid, equal to active EN delayed by the pipeline

## Operation
- Reset values:
  - shadow and active FREQ=0, PHASE=0, MODE=0 (sine), DUTY=M, AMP=2^W (unity), EN=0;
  - accumulators 0;
  - all pipeline stages 0 / midscale;
  - `wave_out`=M on every channel, `wave_valid`=0.
- Accumulator: `acc <= acc + FREQ_active` each clock while EN_active=1; holds while EN_active=0; wraps modulo 2^PHASE_WIDTH.
- Phase sum: `ps = acc + PHASE_active` (mod 2^PHASE_WIDTH). `p` = top W bits of `ps`.
- Waveform by MODE:
  - 0 sine: quarter-wave LUT. The top 2 bits of `ps` select the quadrant (address mirror / sign flip). The next LUT_ADDR_WIDTH bits address the LUT. Value = M + round((M-1)·sin θ), range 1..2^W-1.
  - 1 triangle: p[W-1]=0 gives {p[W-2:0],0}; p[W-1]=1 gives ~{p[W-2:0],0}.
  - 2 sawtooth: p.
  - 3 square: (p < DUTY) ? 2^W-1 : 0. DUTY is W+1 bits: 0 means always low, 2^W means always high.
  - 4-7: constant M.
- Amplitude: `out = M + ((raw - M)·AMP) >>> W`. Signed math, arithmetic shift (floor). AMP=2^W is exact bypass. The result always fits in W bits for AMP <= 2^W. AMP > 2^W saturates to 0 / 2^W-1.
- Disabled channel: output stage forces M, `wave_valid`=0.
- Shadow registers:
  - `cfg_wr` changes only the shadow; the active register and the output are unaffected until `update`.
  - `cfg_wr` and `update` in the same cycle: the written value is included in the copy.
- `sync`:
  - All accumulators load 0 at that edge, regardless of EN.
  - `sync` with `update` in the same cycle: acc=0 and the new FREQ is added from the following edge.
- Reset mid-operation overrides `cfg_wr`/`update`/`sync`. All state returns to reset values at that edge.

## Timing
- Pipeline from accumulator register to `wave_out`: stage1 `ps` register, stage2 raw waveform (registered LUT read), stage3 scaled output. `wave_out` reflects the acc value 3 clocks earlier.
- `update` at edge N: active regs change at N. Acc uses the new FREQ at edge N+1. Output reflects the new PHASE/MODE/DUTY/AMP at N+3.
- EN 0→1 via update at N: `wave_valid` rises at N+3. 1→0: falls at N+3, with `wave_out`=M at the same edge.
- `sync` at edge N: acc=0 at N. `wave_out` shows the ps=PHASE sample at N+3.
- Reset: `wave_out`=M and `wave_valid`=0 from the reset edge. The first valid sample appears 3 clocks after an enabling `update`.
- Throughput: one sample per channel per clock. No backpressure.

## Test plan
- Reset, CH0 FREQ=0x028F5C29, MODE=0, EN=1, update: `wave_valid[0]` rises 3 clocks later; period 100±1 clocks; max 4095, min 1; CH1 stays at 2048, valid 0.
- CH0/CH1 FREQ=0x01000000, MODE=2, CH1 PHASE=0x40000000, update+sync: CH1 − CH0 = 1024 (mod 4096) on every valid sample; first samples CH0=0, CH1=1024.
- MODE=3, FREQ=0x01000000, DUTY=1024: high (4095) 64 clocks / low (0) 192 clocks per period; DUTY=0 gives constant 0; DUTY=4096 gives constant 4095.
- MODE=2, AMP=2048: raw 0 gives 1024, raw 4095 gives 3071; AMP=0 gives constant 2048.
- Shadow/atomicity: write both channels' FREQ with no update: outputs unchanged for 200 clocks. Then update: both channels' slopes change at the same edge+3. Writes to cfg_ch=CHANNELS and to cfg_addr=6 have no effect.
- Assert reset for 1 clock mid-run: `wave_out`=2048 and `wave_valid`=0 at that edge; outputs stay midscale until a new update.
